// File: rtl/st_drain_ctrl_if.sv
// st_drain_ctrl_if: store request/response handshake between the write buffer and the memory store port
interface st_drain_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   dc2memStAddr;
  logic [DATA_W-1:0]   dc2memStData;
  logic [DATA_W/8-1:0] dc2memStByteEn;
  logic                dc2memStValid;
  logic                mem2dcStStall;
  logic                mem2dcStComplete;
  modport master (
    output dc2memStAddr, dc2memStData, dc2memStByteEn, dc2memStValid,
    input  mem2dcStStall, mem2dcStComplete
  );
  modport slave (
    input  dc2memStAddr, dc2memStData, dc2memStByteEn, dc2memStValid,
    output mem2dcStStall, mem2dcStComplete
  );
endinterface

// File: rtl/st_drain_ctrl.sv
// st_drain_ctrl: store write-buffer drain controller; define ST_WB_COALESCE_EN to merge same-word pushes into the newest entry
module st_drain_ctrl #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    commitSt_i,
  input  logic [ADDR_W-1:0]       commitStAddr_i,
  input  logic [DATA_W-1:0]       commitStData_i,
  input  logic [DATA_W/8-1:0]     commitStByteEn_i,
  output logic                    stallStCommit_o,
  st_drain_ctrl_if.master         mem,
  input  logic [ADDR_W-1:0]       ldAddr_i,
  output logic                    ldConflict_o,
  output logic [$clog2(DEPTH):0]  wbCount_o,
  output logic                    overflowErr_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t            state;
  logic [ADDR_W-1:0] addrQ [DEPTH];
  logic [DATA_W-1:0] dataQ [DEPTH];
  logic [BW-1:0]     beQ   [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [PW:0]       count, countNext;
  logic              valid, accept, alloc, pop;
  logic              unusedLdBits;
  assign accept = commitSt_i && !stallStCommit_o;
  assign pop = state == WAIT && mem.mem2dcStComplete;
`ifdef ST_WB_COALESCE_EN
  logic [PW-1:0] newest;
  logic          merge;
  assign newest = tail - PW'(1);
  assign merge = accept && count != '0 && !(count == (PW+1)'(1) && state != IDLE) &&
                 addrQ[newest][ADDR_W-1:2] == commitStAddr_i[ADDR_W-1:2];
  assign alloc = accept && !merge;
`else
  assign alloc = accept;
`endif
  assign countNext = count + (PW+1)'(alloc) - (PW+1)'(pop);
  assign stallStCommit_o = count == (PW+1)'(DEPTH);
  assign wbCount_o = count;
  assign unusedLdBits = ^ldAddr_i[1:0];
  assign mem.dc2memStValid  = valid;
  assign mem.dc2memStAddr   = valid ? addrQ[head] : '0;
  assign mem.dc2memStData   = valid ? dataQ[head] : '0;
  assign mem.dc2memStByteEn = valid ? beQ[head]   : '0;
  // Buffer storage and pointers: allocate at tail, merge into newest, pop head on completion
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addrQ[i] <= '0;
        dataQ[i] <= '0;
        beQ[i]   <= '0;
      end
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      overflowErr_o <= 1'b0;
    end else begin
      if (alloc) begin
        addrQ[tail] <= commitStAddr_i;
        dataQ[tail] <= commitStData_i;
        beQ[tail]   <= commitStByteEn_i;
        tail        <= tail + PW'(1);
      end
`ifdef ST_WB_COALESCE_EN
      if (merge) begin
        beQ[newest] <= beQ[newest] | commitStByteEn_i;
        for (int b = 0; b < BW; b++)
          if (commitStByteEn_i[b]) dataQ[newest][8*b +: 8] <= commitStData_i[8*b +: 8];
      end
`endif
      if (pop) head <= head + PW'(1);
      count <= countNext;
      if (commitSt_i && stallStCommit_o) overflowErr_o <= 1'b1;
    end
  // Drain FSM: present the head entry, hold it through memory stall, then wait for completion
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      valid <= 1'b0;
    end else
      case (state)
        IDLE:  if (count != '0) begin
                 state <= ISSUE;
                 valid <= 1'b1;
               end
        ISSUE: if (!mem.mem2dcStStall) begin
                 state <= WAIT;
                 valid <= 1'b0;
               end
        WAIT:  if (mem.mem2dcStComplete) begin
                 state <= countNext != '0 ? ISSUE : IDLE;
                 valid <= countNext != '0;
               end
        default: begin
                 state <= IDLE;
                 valid <= 1'b0;
               end
      endcase
  // Load probe: word match against every occupied entry, in-flight head included
  always_comb begin
    ldConflict_o = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if ({1'b0, PW'(i) - head} < count && addrQ[i][ADDR_W-1:2] == ldAddr_i[ADDR_W-1:2])
        ldConflict_o = 1'b1;
  end
endmodule
